qedmma_fp_divsqrt: RTL and testbench
====================================

Name: qedmma_fp_divsqrt

Overview:
- Iterative, handshaked fixed-point divide / square-root unit that replaces the combinational divide and square-root helpers used in the tracker datapath.
- Computes one quotient or root bit per cycle with a deterministic latency.
- Parametrised in word width and fraction width.
- Carries a per-target tag so the multi-target IMM/smoother pipelines can share a single instance.

Parameters:
- DATA_WIDTH, 32, operand/result word width (signed, two's complement).
- FRAC_BITS, 16, fractional bits (Q(DATA_WIDTH-FRAC_BITS-1).FRAC_BITS).
- TAG_W, 3, width of opaque tag passed from input to output (8 targets).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- in_mode  in  1  0 = divide a/b, 1 = sqrt(a).
- in_a  in  DATA_WIDTH  dividend or radicand.
- in_b  in  DATA_WIDTH  divisor (ignored in sqrt mode).
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  DATA_WIDTH  result.
- out_tag  out  TAG_W  tag of the accepted request.
- out_div0  out  1  divide mode with b == 0.
- out_neg  out  1  sqrt mode with a < 0.
- out_ovf  out  1  divide result saturated.

Behaviour:
- Reset: asynchronous active-low. All outputs 0 except in_ready, which becomes 1 once out of reset. FSM returns to IDLE.
- Reset mid-operation: abort, discard operands, no out_valid.
- Let M = DATA_WIDTH + FRAC_BITS (48 at defaults).
  - N_DIV = M iterations.
  - N_SQRT = ceil(M/2) iterations, with the radicand zero-padded to an even width.
- FSM states: IDLE → PREP → ITER → POST → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid && in_ready: latch mode, a, b, tag; go to PREP.
- PREP (1 cycle):
  - Divide: form |a| << FRAC_BITS (M bits) and |b|; record result sign = a[MSB] ^ b[MSB].
  - Sqrt: form a << FRAC_BITS.
  - Clear remainder; load the iteration counter.
- ITER:
  - Divide: restoring division, one bit per cycle, MSB first, N_DIV cycles.
  - Sqrt: digit-by-digit restoring integer square root, two radicand bits per cycle, N_SQRT cycles.
  - The counter decrements each cycle; exit to POST when it reaches 0.
- POST (1 cycle):
  - Apply the sign (divide).
  - Saturate: magnitude > 2^(DATA_WIDTH-1)-1 for a positive result, or > 2^(DATA_WIDTH-1) for a negative result, gives 0x7FFF_FFFF / 0x8000_0000 and sets out_ovf.
  - Register the flags.
- DONE:
  - out_valid = 1.
  - out_result, out_tag and the flags stay stable until out_ready.
  - On out_ready, drop out_valid and go to IDLE.
- Latency: out_valid rises exactly N+2 cycles after the accepting edge (50 cycles for divide, 26 for sqrt at defaults).
- Throughput: one operation in flight. in_ready = 0 outside IDLE, giving a minimum 1-cycle bubble between a result handshake and the next accept.
- Special cases still consume the full latency, so timing is deterministic:
  - Divide with b == 0: result 0x7FFF_FFFF if a ≥ 0, else 0x8000_0000; out_div0 = 1; out_ovf = 0.
  - Sqrt with a < 0: result 0, out_neg = 1.
  - Sqrt with a == 0: result 0, no flag.
- Default rounding: divide truncates toward zero on magnitude; sqrt uses floor.
- Flags are mutually exclusive and valid only while out_valid = 1.
- in_b is don't-care in sqrt mode; out_div0 and out_ovf are 0 in sqrt mode.

Optional Feature:
- Macro: QEDMMA_DIVSQRT_ROUND_EN.
- Defined: round to nearest, costing one extra ITER cycle in both modes (latency N+3).
  - Divide: compute one extra quotient bit; round half away from zero on magnitude before saturation (a carry into overflow saturates and sets out_ovf).
  - Sqrt: increment the root if remainder > root.
- Undefined: truncate/floor with latency N+2, as above.

Test Plan:
- Divide: a=0x0003_0000, b=0x0002_0000 → out_result=0x0001_8000 at 50 cycles after accept, no flags.
- Signed divide and overflow:
  - a=0xFFFD_0000 (-3.0), b=0x0002_0000 → 0xFFFE_8000.
  - a=0x4000_0000, b=0x0000_8000 → 0x7FFF_FFFF, out_ovf=1.
- Sqrt: a=0x0004_0000 → 0x0002_0000 at 26 cycles; a=0x0002_0000 → 0x0001_6A09 (0x0001_6A0A with QEDMMA_DIVSQRT_ROUND_EN, at 27 cycles).
- Special cases:
  - Divide a=0xFFFF_0000, b=0 → 0x8000_0000, out_div0=1.
  - Sqrt a=0xFFFF_0000 → 0, out_neg=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result, tag and flags stable, in_ready=0. Release → in_ready=1 on the following cycle; a back-to-back request with in_tag=5 returns out_tag=5.
- Reset mid-op: assert rst_n=0 at ITER cycle 20 → out_valid=0, in_ready=1 after reset release. The next request completes with the correct value and nominal latency.

Source files
------------

// File: rtl/qedmma_fp_divsqrt.sv
// Iterative fixed-point divide / square-root unit with tag pass-through.
// QEDMMA_DIVSQRT_ROUND_EN: round-to-nearest with one extra iteration cycle.
module qedmma_fp_divsqrt #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int TAG_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_div0,
  output logic                  out_neg,
  output logic                  out_ovf
);

  localparam int DW = DATA_WIDTH;
  localparam int M  = DATA_WIDTH + FRAC_BITS;
`ifdef QEDMMA_DIVSQRT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int QW = M + RND;
  localparam int MW = M + 1;
  localparam int NS = (M + 1) / 2;
  localparam int SW = 2 * NS;
  localparam int RW = NS + 2;
  localparam int CW = $clog2(QW + 2);

  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam logic [MW-1:0] LIM  = MW'(1) << (DW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_POST,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic live_q;

  logic mode_q, mode_d;
  logic sign_q, sign_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [QW-1:0] dq_q, dq_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [SW-1:0] rad_q, rad_d;
  logic [NS-1:0] root_q, root_d;
  logic [RW-1:0] srem_q, srem_d;

  logic [DW-1:0] res_q, res_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic div0_q, div0_d;
  logic neg_q, neg_d;
  logic ovf_q, ovf_d;

  logic [DW-1:0] abs_a, abs_b;
  logic [QW-1:0] dvd;
  logic [DW:0] rem_sh;
  logic div_ge;
  logic [DW-1:0] rem_nx;
  logic [RW+1:0] sq_tmp, sq_trial;
  logic sq_ge;
  logic [RW-1:0] srem_nx;
  logic sq_step;
  logic [MW-1:0] mag;
  logic div_sat;
  logic [DW-1:0] mag_lo, div_val;
  logic [NS-1:0] root_fin;
  logic [DW-1:0] sq_val;

  assign in_ready  = live_q && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_tag   = otag_q;
  assign out_div0  = div0_q;
  assign out_neg   = neg_q;
  assign out_ovf   = ovf_q;

  assign abs_a = a_q[DW-1] ? -a_q : a_q;
  assign abs_b = b_q[DW-1] ? -b_q : b_q;
  // Extra low zero bit in round mode yields the half-LSB quotient bit.
  assign dvd   = QW'({abs_a, {FRAC_BITS{1'b0}}}) << RND;

  assign rem_sh = {rem_q, dq_q[QW-1]};
  assign div_ge = rem_sh >= {1'b0, b_q};
  assign rem_nx = div_ge ? DW'(rem_sh - {1'b0, b_q})
                         : DW'(rem_sh);

  assign sq_tmp   = {srem_q, rad_q[SW-1 -: 2]};
  assign sq_trial = {2'b00, root_q, 2'b01};
  assign sq_ge    = sq_tmp >= sq_trial;
  assign srem_nx  = sq_ge ? RW'(sq_tmp - sq_trial)
                          : RW'(sq_tmp);

`ifdef QEDMMA_DIVSQRT_ROUND_EN
  assign sq_step  = (cnt_q != CW'(1));
  assign mag      = {1'b0, dq_q[QW-1:1]} + MW'(dq_q[0]);
  assign root_fin = root_q + NS'(srem_q > RW'(root_q));
`else
  assign sq_step  = 1'b1;
  assign mag      = {1'b0, dq_q};
  assign root_fin = root_q;
`endif

  assign div_sat = sign_q ? (mag > LIM) : (mag >= LIM);
  assign mag_lo  = mag[DW-1:0];
  assign div_val = sign_q ? -mag_lo : mag_lo;
  assign sq_val  = DW'(root_fin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      mode_q  <= 1'b0;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      rad_q   <= '0;
      root_q  <= '0;
      srem_q  <= '0;
      res_q   <= '0;
      otag_q  <= '0;
      div0_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      srem_q  <= srem_d;
      res_q   <= res_d;
      otag_q  <= otag_d;
      div0_q  <= div0_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    rad_d   = rad_q;
    root_d  = root_q;
    srem_d  = srem_q;
    res_d   = res_q;
    otag_d  = otag_q;
    div0_d  = div0_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          mode_d  = in_mode;
          a_d     = in_a;
          b_d     = in_b;
          tag_d   = in_tag;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d  = a_q[DW-1] ^ b_q[DW-1];
        b_d     = abs_b;
        dq_d    = dvd;
        rem_d   = '0;
        rad_d   = SW'({a_q, {FRAC_BITS{1'b0}}});
        root_d  = '0;
        srem_d  = '0;
        cnt_d   = mode_q ? CW'(NS + RND) : CW'(QW);
        state_d = S_ITER;
      end
      S_ITER: begin
        cnt_d = cnt_q - 1'b1;
        if (!mode_q) begin
          dq_d  = {dq_q[QW-2:0], div_ge};
          rem_d = rem_nx;
        end else if (sq_step) begin
          rad_d  = rad_q << 2;
          root_d = {root_q[NS-2:0], sq_ge};
          srem_d = srem_nx;
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_POST;
        end
      end
      S_POST: begin
        otag_d = tag_q;
        div0_d = 1'b0;
        neg_d  = 1'b0;
        ovf_d  = 1'b0;
        if (!mode_q) begin
          if (b_q == '0) begin
            div0_d = 1'b1;
            res_d  = a_q[DW-1] ? MINV : MAXV;
          end else if (div_sat) begin
            ovf_d = 1'b1;
            res_d = sign_q ? MINV : MAXV;
          end else begin
            res_d = div_val;
          end
        end else if (a_q[DW-1]) begin
          neg_d = 1'b1;
          res_d = '0;
        end else begin
          res_d = sq_val;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_qedmma_fp_divsqrt.sv
// Bench for qedmma_fp_divsqrt: arithmetic reference model, directed
// test-plan cases and randomized operations through one compare monitor.
module tb_qedmma_fp_divsqrt;

`ifdef QEDMMA_DIVSQRT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_tag;
  logic        out_div0;
  logic        out_neg;
  logic        out_ovf;

  qedmma_fp_divsqrt #(
    .DATA_WIDTH(32),
    .FRAC_BITS (16),
    .TAG_W     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .out_div0  (out_div0),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic [31:0] res;
    bit div0;
    bit neg;
    bit ovf;
  } exp_t;

  typedef struct {
    exp_t e;
    logic [2:0] tag;
    int acc;
    int lat;
    bit seen;
    bit has_lit;
    logic [31:0] lit;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit hs_prev = 0;
  bit lit_en = 0;
  logic [31:0] lit_v = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #3000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req,
               $time);
    end
  endtask

  function automatic exp_t model(input bit mode, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t r;
    longint sa, sb, ma, mb, num, qt, x, rt;
    bit ng;
    r.res = '0;
    r.div0 = 0;
    r.neg = 0;
    r.ovf = 0;
    if (!mode) begin
      if (b == 0) begin
        r.div0 = 1;
        r.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        num = ma * 65536;
        if (RND == 1) qt = ((2 * num) / mb + 1) / 2;
        else qt = num / mb;
        ng = (sa < 0) != (sb < 0);
        if (!ng && qt > 64'sh7FFF_FFFF) begin
          r.ovf = 1;
          r.res = 32'h7FFF_FFFF;
        end else if (ng && qt > 64'sh8000_0000) begin
          r.ovf = 1;
          r.res = 32'h8000_0000;
        end else begin
          r.res = ng ? 32'(-qt) : 32'(qt);
        end
      end
    end else if (a[31]) begin
      r.neg = 1;
    end else begin
      x = longint'(a) * 65536;
      rt = longint'($sqrt(real'(x)));
      while (rt * rt > x) rt--;
      while ((rt + 1) * (rt + 1) <= x) rt++;
      if (RND == 1 && (x - rt * rt) > rt) rt++;
      r.res = 32'(rt);
    end
    return r;
  endfunction

  // Single compare process: checks outputs every cycle they mean something.
  always @(negedge clk) begin
    ent_t n;
    exp_t e;
    if (!rst_n) begin
      chk("rst_valid", 64'(out_valid), 64'd0);
      q.delete();
      hs_prev = 0;
    end else begin
      if (hs_prev) begin
        chk("hs_ready", 64'(in_ready), 64'd1);
        chk("hs_valid", 64'(out_valid), 64'd0);
      end
      hs_prev = 0;
      if (q.size() == 0) begin
        chk("idle_valid", 64'(out_valid), 64'd0);
      end else if (!out_valid) begin
        chk("busy_ready", 64'(in_ready), 64'd0);
      end else begin
        if (!q[0].seen) begin
          chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
          if (q[0].has_lit) chk("literal", 64'(out_result), 64'(q[0].lit));
          q[0].seen = 1;
        end
        e = q[0].e;
        chk("result", 64'(out_result), 64'(e.res));
        chk("tag", 64'(out_tag), 64'(q[0].tag));
        chk("div0", 64'(out_div0), 64'(e.div0));
        chk("neg", 64'(out_neg), 64'(e.neg));
        chk("ovf", 64'(out_ovf), 64'(e.ovf));
        chk("valid_ready", 64'(in_ready), 64'd0);
        if (out_ready) begin
          void'(q.pop_front());
          hs_prev = 1;
        end
      end
      if (in_valid && in_ready) begin
        n.e = model(in_mode, in_a, in_b);
        n.tag = in_tag;
        n.acc = cyc + 1;
        n.lat = (in_mode ? 24 : 48) + 2 + RND;
        n.seen = 0;
        n.has_lit = lit_en;
        n.lit = lit_v;
        q.push_back(n);
      end
    end
  end

  // Caller is positioned just after a rising edge.
  task automatic send(input bit mode, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] tag,
                      input bit le, input logic [31:0] lv);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid = 1;
    in_mode = mode;
    in_a = a;
    in_b = b;
    in_tag = tag;
    lit_en = le;
    lit_v = lv;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_a = $urandom;
    in_b = $urandom;
    in_tag = 3'($urandom);
    in_mode = 1'($urandom);
  endtask

  task automatic finish_op(input int hold);
    int n = 0;
    out_ready = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      chk("result_timeout", 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
  endtask

  task automatic op(input bit mode, input logic [31:0] a,
                    input logic [31:0] b, input logic [2:0] tag,
                    input bit le, input logic [31:0] lv, input int hold);
    send(mode, a, b, tag, le, lv);
    finish_op(hold);
  endtask

  initial begin
    exp_t m;
    logic [31:0] ra, rb;
    bit md;
    rst_n = 1;
    in_valid = 0;
    in_mode = 0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 0;
    #1 rst_n = 0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_flags", 64'({out_div0, out_neg, out_ovf}), 64'd0);

    m = model(0, 32'h0003_0000, 32'h0002_0000);
    chk("pin_div", 64'(m.res), 64'h0001_8000);
    m = model(0, 32'hFFFD_0000, 32'h0002_0000);
    chk("pin_sdiv", 64'(m.res), 64'hFFFE_8000);
    m = model(0, 32'h4000_0000, 32'h0000_8000);
    chk("pin_ovf", 64'({m.ovf, m.res}), 64'h1_7FFF_FFFF);
    m = model(1, 32'h0002_0000, 32'h0);
    chk("pin_sqrt2", 64'(m.res), RND ? 64'h0001_6A0A : 64'h0001_6A09);

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    op(0, 32'h0003_0000, 32'h0002_0000, 3'd1, 1, 32'h0001_8000, 0);
    op(0, 32'hFFFD_0000, 32'h0002_0000, 3'd2, 1, 32'hFFFE_8000, 0);
    op(0, 32'h4000_0000, 32'h0000_8000, 3'd3, 1, 32'h7FFF_FFFF, 0);
    op(1, 32'h0004_0000, 32'h1234_5678, 3'd4, 1, 32'h0002_0000, 0);
    op(1, 32'h0002_0000, 32'h0, 3'd6, 1,
       RND ? 32'h0001_6A0A : 32'h0001_6A09, 0);
    op(0, 32'hFFFF_0000, 32'h0, 3'd7, 1, 32'h8000_0000, 0);
    op(1, 32'hFFFF_0000, 32'h0, 3'd0, 1, 32'h0, 0);
    op(1, 32'h0, 32'h0, 3'd1, 1, 32'h0, 0);
    op(0, 32'h8000_0000, 32'hFFFF_0000, 3'd2, 0, 32'h0, 1);
    op(0, 32'h8000_0000, 32'h0001_0000, 3'd3, 1, 32'h8000_0000, 0);

    op(0, 32'h0007_0000, 32'hFFFE_0000, 3'd2, 0, 32'h0, 10);
    op(1, 32'h0009_0000, 32'h0, 3'd5, 1, 32'h0003_0000, 0);

    send(0, 32'h0010_0000, 32'h0003_0000, 3'd4, 0, 32'h0);
    repeat (21) @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_valid2", 64'(out_valid), 64'd0);
    op(0, 32'h0003_0000, 32'h0002_0000, 3'd6, 1, 32'h0001_8000, 0);

    for (int i = 0; i < 300; i++) begin
      md = 1'($urandom);
      case ($urandom_range(0, 2))
        0: ra = $urandom;
        1: ra = 32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;
        default: ra = 32'($urandom_range(0, 32'h7FF));
      endcase
      case ($urandom_range(0, 15))
        0: rb = 32'h0;
        1, 2, 3, 4, 5: rb = 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000;
        6, 7: rb = 32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      op(md, ra, rb, 3'($urandom), 0, 32'h0, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
